lsu_mem_sched: RTL and testbench

- In-order memory-request scheduler between the issue stage and the dual-port data memory (port 0 write, port 1 read; active-low chip selects; 1-cycle read latency).
- Buffers up to DEPTH dispatched loads/stores and issues them strictly in program order, one at a time, from the queue head.
- Holds stores at the head until the ROB commits them.
- Formats load data and returns it with its ROB tag; flags misaligned accesses.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_mem_sched_if.sv | 49 ++++
 rtl/lsu_load_align.sv | 24 ++
 rtl/lsu_mem_sched.sv | 151 +++++++++++++++
 tb/tb_lsu_mem_sched.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store scheduler: access sizes, FSM states,
// queue-entry field offsets and store lane/mask helpers.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_C = 2'd1,
        ST_RESP   = 2'd2,
        ST_FAULT  = 2'd3
    } state_e;

    // Flat entry layout, low to high: ls, signed, size, wdata, addr, tag.
    localparam int E_LS   = 0;
    localparam int E_SGN  = 1;
    localparam int E_SZ   = 2;
    localparam int E_WD   = 4;
    localparam int E_ADDR = 36;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_B:    return {4{wd[7:0]}};
            SZ_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_sched_if.sv
// Request, commit, flush, data-memory and writeback signals of the scheduler.
// slave is the scheduler's view; master is the surrounding pipeline/memory view.
interface lsu_mem_sched_if #(
    parameter int DMEM_ADDR_LEN = 8,
    parameter int ADDR_LEN      = 2,
    parameter int TAG_W         = 4
);
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic                     req_ls_i;
    logic [1:0]               req_size_i;
    logic                     req_signed_i;
    logic [DMEM_ADDR_LEN-1:0] req_addr_i;
    logic [31:0]              req_wdata_i;
    logic [TAG_W-1:0]         req_tag_i;
    logic                     store_commit_i;
    logic [TAG_W-1:0]         store_commit_tag_i;
    logic                     flush_i;
    logic                     mem_csb_r_o;
    logic                     mem_csb_w_o;
    logic [DMEM_ADDR_LEN-3:0] mem_addr_r_o;
    logic [DMEM_ADDR_LEN-3:0] mem_addr_w_o;
    logic [3:0]               mem_wmask_o;
    logic [31:0]              mem_wdata_o;
    logic [31:0]              mem_rdata_i;
    logic                     wb_valid_o;
    logic [TAG_W-1:0]         wb_tag_o;
    logic [31:0]              wb_value_o;
    logic                     wb_misaligned_o;
    logic [ADDR_LEN:0]        count_o;

    modport slave (
        input  req_valid_i, req_ls_i, req_size_i, req_signed_i, req_addr_i,
               req_wdata_i, req_tag_i, store_commit_i, store_commit_tag_i,
               flush_i, mem_rdata_i,
        output req_ready_o, mem_csb_r_o, mem_csb_w_o, mem_addr_r_o, mem_addr_w_o,
               mem_wmask_o, mem_wdata_o, wb_valid_o, wb_tag_o, wb_value_o,
               wb_misaligned_o, count_o
    );

    modport master (
        output req_valid_i, req_ls_i, req_size_i, req_signed_i, req_addr_i,
               req_wdata_i, req_tag_i, store_commit_i, store_commit_tag_i,
               flush_i, mem_rdata_i,
        input  req_ready_o, mem_csb_r_o, mem_csb_w_o, mem_addr_r_o, mem_addr_w_o,
               mem_wmask_o, mem_wdata_o, wb_valid_o, wb_tag_o, wb_value_o,
               wb_misaligned_o, count_o
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load-data formatter: picks the byte/half lane addressed by off, moves it to
// bit 0 and sign- or zero-extends it. Purely combinational.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] result
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{off, 3'b000} +: 8];
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_B:    result = {{24{sgn & lane_b[7]}}, lane_b};
            SZ_H:    result = {{16{sgn & lane_h[15]}}, lane_h};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/lsu_mem_sched.sv
// In-order load/store scheduler in front of a 1-read/1-write data memory.
// Loads return 2 cycles after enqueue into an empty queue; stores wait at the head for ROB commit.
module lsu_mem_sched
    import lsu_pkg::*;
#(
    parameter int DMEM_ADDR_LEN = 8,
    parameter int DEPTH         = 4,
    parameter int ADDR_LEN      = 2,
    parameter int TAG_W         = 4
) (
    input logic            clk_i,
    input logic            reset_i,
    lsu_mem_sched_if.slave bus
);
    localparam int EW    = E_ADDR + DMEM_ADDR_LEN + TAG_W;
    localparam int CNT_W = ADDR_LEN + 1;

    logic [EW-1:0]       q [DEPTH];
    logic [ADDR_LEN-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count;
    state_e              state, state_n;

    logic [TAG_W-1:0] r_tag;
    logic [1:0]       r_off;
    logic [1:0]       r_size;
    logic             r_sgn;

    logic                     push, pop, capture, rd_issue, wr_issue, rd_go, wr_go, ready;
    logic [EW-1:0]            head;
    logic                     head_ls, head_sgn, head_mis;
    logic [1:0]               head_size;
    logic [31:0]              head_wdata;
    logic [DMEM_ADDR_LEN-1:0] head_addr;
    logic [TAG_W-1:0]         head_tag;
    logic [31:0]              aligned;

    assign head       = q[rd_ptr];
    assign head_ls    = head[E_LS];
    assign head_sgn   = head[E_SGN];
    assign head_size  = head[E_SZ +: 2];
    assign head_wdata = head[E_WD +: 32];
    assign head_addr  = head[E_ADDR +: DMEM_ADDR_LEN];
    assign head_tag   = head[E_ADDR + DMEM_ADDR_LEN +: TAG_W];
    assign head_mis   = is_misaligned(head_size, head_addr[1:0]);

    assign ready = count < CNT_W'(DEPTH);
    // Requests arriving alongside a flush belong to the squashed path.
    assign push  = bus.req_valid_i & ready & ~bus.flush_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            q[wr_ptr] <= {bus.req_tag_i, bus.req_addr_i, bus.req_wdata_i,
                          bus.req_size_i, bus.req_signed_i, bus.req_ls_i};
        end
    end

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        capture  = 1'b0;
        rd_issue = 1'b0;
        wr_issue = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    if (head_mis) begin
                        pop     = 1'b1;
                        capture = 1'b1;
                        state_n = ST_FAULT;
                    end else if (head_ls) begin
                        rd_issue = 1'b1;
                        pop      = 1'b1;
                        capture  = 1'b1;
                        state_n  = ST_RESP;
                    end else begin
                        state_n = ST_WAIT_C;
                    end
                end
            end
            ST_WAIT_C: begin
                if (bus.store_commit_i && (bus.store_commit_tag_i == head_tag)) begin
                    wr_issue = 1'b1;
                    pop      = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            ST_RESP:  state_n = ST_IDLE;
            ST_FAULT: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
        if (bus.flush_i) begin
            state_n = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state  <= ST_IDLE;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            r_tag  <= '0;
            r_off  <= '0;
            r_size <= SZ_W;
            r_sgn  <= 1'b0;
        end else begin
            state <= state_n;
            if (bus.flush_i) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + ADDR_LEN'(1);
                if (pop)  rd_ptr <= rd_ptr + ADDR_LEN'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (!push && pop) count <= count - CNT_W'(1);
            end
            if (capture) begin
                r_tag  <= head_tag;
                r_off  <= head_addr[1:0];
                r_size <= head_size;
                r_sgn  <= head_sgn;
            end
        end
    end

    lsu_load_align u_align (
        .rdata  (bus.mem_rdata_i),
        .off    (r_off),
        .size   (r_size),
        .sgn    (r_sgn),
        .result (aligned)
    );

    // Reset wins over any issue decision made this cycle.
    assign rd_go = rd_issue & reset_i;
    assign wr_go = wr_issue & reset_i;

    assign bus.req_ready_o     = ready;
    assign bus.count_o         = count;
    assign bus.mem_csb_r_o     = ~rd_go;
    assign bus.mem_csb_w_o     = ~wr_go;
    assign bus.mem_addr_r_o    = rd_go ? head_addr[DMEM_ADDR_LEN-1:2] : '0;
    assign bus.mem_addr_w_o    = wr_go ? head_addr[DMEM_ADDR_LEN-1:2] : '0;
    assign bus.mem_wmask_o     = wr_go ? store_mask(head_size, head_addr[1:0]) : 4'b0000;
    assign bus.mem_wdata_o     = wr_go ? store_lanes(head_size, head_wdata) : 32'd0;
    assign bus.wb_valid_o      = (state == ST_RESP) || (state == ST_FAULT);
    assign bus.wb_tag_o        = bus.wb_valid_o ? r_tag : '0;
    assign bus.wb_value_o      = (state == ST_RESP) ? aligned : 32'd0;
    assign bus.wb_misaligned_o = (state == ST_FAULT);
endmodule

// File: tb/tb_lsu_mem_sched.sv
module tb_lsu_mem_sched;
    import lsu_pkg::*;

    localparam int DA = 8;
    localparam int DEPTH = 4;
    localparam int AL = 2;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_sched_if #(.DMEM_ADDR_LEN(DA), .ADDR_LEN(AL), .TAG_W(TW)) bus ();

    lsu_mem_sched #(.DMEM_ADDR_LEN(DA), .DEPTH(DEPTH), .ADDR_LEN(AL), .TAG_W(TW)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [31:0]   value;
        logic          mis;
    } wb_t;
    wb_t sb[$];
    wb_t exp_wb;

    // Data memory model: 1-cycle registered read, byte-masked write, backdoor preload.
    logic [31:0] tbmem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] rdata_q = '0;
    assign bus.mem_rdata_i = rdata_q;

    always @(posedge clk) begin
        if (pre_we) tbmem[pre_addr] <= pre_data;
        if (!bus.mem_csb_r_o) rdata_q <= tbmem[bus.mem_addr_r_o];
        if (!bus.mem_csb_w_o)
            for (int i = 0; i < 4; i++)
                if (bus.mem_wmask_o[i]) tbmem[bus.mem_addr_w_o][8*i +: 8] <= bus.mem_wdata_o[8*i +: 8];
    end

    // Writeback monitor: every result is popped against the scoreboard.
    always @(negedge clk) begin
        checks++;
        if (!bus.mem_csb_r_o && !bus.mem_csb_w_o) begin
            errors++; $display("FAIL both_csb got csb_r=0 csb_w=0 exp at most one low");
        end
        if (bus.wb_valid_o === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL wb_unexpected got tag=%0d value=%h exp no writeback", bus.wb_tag_o, bus.wb_value_o);
            end else begin
                exp_wb = sb.pop_front();
                if (bus.wb_tag_o !== exp_wb.tag || bus.wb_value_o !== exp_wb.value || bus.wb_misaligned_o !== exp_wb.mis) begin
                    errors++;
                    $display("FAIL wb_result got tag=%0d value=%h mis=%b exp tag=%0d value=%h mis=%b",
                             bus.wb_tag_o, bus.wb_value_o, bus.wb_misaligned_o, exp_wb.tag, exp_wb.value, exp_wb.mis);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid_i = 0; bus.req_ls_i = 0; bus.req_size_i = SZ_W; bus.req_signed_i = 0;
        bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.req_tag_i = '0;
        bus.store_commit_i = 0; bus.store_commit_tag_i = '0; bus.flush_i = 0;
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        cyc();
        pre_we = 1'b0;
    endtask

    task automatic drive_req(input logic ls, input logic [1:0] sz, input logic sgn,
                             input logic [DA-1:0] addr, input logic [31:0] wd, input logic [TW-1:0] tag);
        bus.req_valid_i = 1; bus.req_ls_i = ls; bus.req_size_i = sz; bus.req_signed_i = sgn;
        bus.req_addr_i = addr; bus.req_wdata_i = wd; bus.req_tag_i = tag;
    endtask

    // Presents one request until accepted; returns 1ns after the accepting edge.
    task automatic push_req(input logic ls, input logic [1:0] sz, input logic sgn,
                            input logic [DA-1:0] addr, input logic [31:0] wd, input logic [TW-1:0] tag);
        int n = 0;
        drive_req(ls, sz, sgn, addr, wd, tag);
        #1;
        while (!bus.req_ready_o && n < 20) begin cyc(); #1; n++; end
        checks++;
        if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL accept_timeout got ready=%b exp 1", bus.req_ready_o); end
        cyc();
        bus.req_valid_i = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((bus.count_o != 0 || sb.size() != 0) && n < 100) begin cyc(); n++; end
        checks++;
        if (bus.count_o !== 3'd0 || sb.size() != 0) begin
            errors++; $display("FAIL drain_timeout got count=%0d pending=%0d exp 0 0", bus.count_o, sb.size());
        end
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs();
        cyc(); cyc(); #1;
        checks += 8;
        if (bus.req_ready_o !== 1'b1)     begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready_o); end
        if (bus.mem_csb_r_o !== 1'b1)     begin errors++; $display("FAIL rst_csb_r got=%b exp=1", bus.mem_csb_r_o); end
        if (bus.mem_csb_w_o !== 1'b1)     begin errors++; $display("FAIL rst_csb_w got=%b exp=1", bus.mem_csb_w_o); end
        if (bus.mem_wmask_o !== 4'b0000)  begin errors++; $display("FAIL rst_wmask got=%b exp=0000", bus.mem_wmask_o); end
        if (bus.wb_valid_o !== 1'b0)      begin errors++; $display("FAIL rst_wb_valid got=%b exp=0", bus.wb_valid_o); end
        if (bus.wb_misaligned_o !== 1'b0) begin errors++; $display("FAIL rst_mis got=%b exp=0", bus.wb_misaligned_o); end
        if (bus.wb_tag_o !== 4'd0 || bus.wb_value_o !== 32'd0) begin errors++; $display("FAIL rst_wb got tag=%0d value=%h exp 0 0", bus.wb_tag_o, bus.wb_value_o); end
        if (bus.count_o !== 3'd0)         begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.count_o); end
        rst_n = 1;
        cyc();
    endtask

    task automatic test_lw();
        preload(6'd4, 32'hDEADBEEF);
        sb.push_back({4'd3, 32'hDEADBEEF, 1'b0});
        drive_req(1, SZ_W, 0, 8'h10, 32'd0, 4'd3);
        #1; checks++;
        if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL lw_ready got=%b exp=1", bus.req_ready_o); end
        cyc();
        bus.req_valid_i = 0; #1;
        checks += 3;
        if (bus.mem_csb_r_o !== 1'b0 || bus.mem_addr_r_o !== 6'h04) begin errors++; $display("FAIL lw_issue got csb_r=%b addr=%h exp 0 04", bus.mem_csb_r_o, bus.mem_addr_r_o); end
        if (bus.mem_csb_w_o !== 1'b1) begin errors++; $display("FAIL lw_csb_w got=%b exp=1", bus.mem_csb_w_o); end
        if (bus.count_o !== 3'd1) begin errors++; $display("FAIL lw_count got=%0d exp=1", bus.count_o); end
        cyc(); #1;
        checks += 2;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_tag_o !== 4'd3) begin errors++; $display("FAIL lw_wb got valid=%b tag=%0d exp 1 3", bus.wb_valid_o, bus.wb_tag_o); end
        if (bus.wb_value_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_value got=%h exp=deadbeef", bus.wb_value_o); end
        cyc(); #1;
        checks++;
        if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL lw_pulse got=%b exp=0", bus.wb_valid_o); end
        wait_drain();
    endtask

    task automatic test_load_format();
        preload(6'd4, 32'h80FF0000);
        sb.push_back({4'd1, 32'hFFFFFF80, 1'b0}); push_req(1, SZ_B, 1, 8'h13, 32'd0, 4'd1);
        sb.push_back({4'd2, 32'h000080FF, 1'b0}); push_req(1, SZ_H, 0, 8'h12, 32'd0, 4'd2);
        sb.push_back({4'd3, 32'h000000FF, 1'b0}); push_req(1, SZ_B, 0, 8'h12, 32'd0, 4'd3);
        sb.push_back({4'd4, 32'hFFFF80FF, 1'b0}); push_req(1, SZ_H, 1, 8'h12, 32'd0, 4'd4);
        sb.push_back({4'd5, 32'h80FF0000, 1'b0}); push_req(1, 2'b11, 0, 8'h10, 32'd0, 4'd5);
        wait_drain();
    endtask

    task automatic test_store();
        preload(6'd2, 32'hAAAAAAAA);
        preload(6'd8, 32'h00000000);
        push_req(0, SZ_H, 0, 8'h0A, 32'h00001234, 4'd5);
        for (int k = 0; k < 3; k++) begin
            #1; checks++;
            if (bus.mem_csb_w_o !== 1'b1) begin errors++; $display("FAIL st_hold got csb_w=%b exp=1", bus.mem_csb_w_o); end
            cyc();
        end
        bus.store_commit_i = 1; bus.store_commit_tag_i = 4'd4; #1;
        checks++;
        if (bus.mem_csb_w_o !== 1'b1) begin errors++; $display("FAIL st_wrong_tag got csb_w=%b exp=1", bus.mem_csb_w_o); end
        cyc();
        bus.store_commit_tag_i = 4'd5; #1;
        checks += 3;
        if (bus.mem_csb_w_o !== 1'b0 || bus.mem_csb_r_o !== 1'b1) begin errors++; $display("FAIL st_commit got csb_w=%b csb_r=%b exp 0 1", bus.mem_csb_w_o, bus.mem_csb_r_o); end
        if (bus.mem_wmask_o !== 4'b1100 || bus.mem_addr_w_o !== 6'h02) begin errors++; $display("FAIL st_mask got mask=%b addr=%h exp 1100 02", bus.mem_wmask_o, bus.mem_addr_w_o); end
        if (bus.mem_wdata_o[31:16] !== 16'h1234) begin errors++; $display("FAIL st_wdata got=%h exp=1234 in upper half", bus.mem_wdata_o); end
        cyc();
        bus.store_commit_i = 0; #1;
        checks++;
        if (bus.count_o !== 3'd0) begin errors++; $display("FAIL st_pop got count=%0d exp=0", bus.count_o); end
        sb.push_back({4'd6, 32'h1234AAAA, 1'b0}); push_req(1, SZ_W, 0, 8'h08, 32'd0, 4'd6);
        wait_drain();
        push_req(0, SZ_B, 0, 8'h21, 32'h000000AB, 4'd7);
        cyc();
        bus.store_commit_i = 1; bus.store_commit_tag_i = 4'd7; #1;
        checks++;
        if (bus.mem_csb_w_o !== 1'b0 || bus.mem_wmask_o !== 4'b0010 || bus.mem_wdata_o !== 32'hABABABAB || bus.mem_addr_w_o !== 6'h08) begin
            errors++; $display("FAIL sb_commit got csb_w=%b mask=%b data=%h addr=%h exp 0 0010 abababab 08",
                               bus.mem_csb_w_o, bus.mem_wmask_o, bus.mem_wdata_o, bus.mem_addr_w_o);
        end
        cyc();
        bus.store_commit_i = 0;
        sb.push_back({4'd8, 32'h0000AB00, 1'b0}); push_req(1, SZ_W, 0, 8'h20, 32'd0, 4'd8);
        wait_drain();
    endtask

    task automatic test_misaligned();
        sb.push_back({4'd7, 32'd0, 1'b1});
        push_req(1, SZ_W, 0, 8'h06, 32'd0, 4'd7);
        #1; checks++;
        if (bus.mem_csb_r_o !== 1'b1 || bus.mem_csb_w_o !== 1'b1) begin errors++; $display("FAIL mis_no_cs got csb_r=%b csb_w=%b exp 1 1", bus.mem_csb_r_o, bus.mem_csb_w_o); end
        cyc(); #1;
        checks++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_misaligned_o !== 1'b1 || bus.wb_tag_o !== 4'd7 || bus.wb_value_o !== 32'd0) begin
            errors++; $display("FAIL mis_fault got valid=%b mis=%b tag=%0d value=%h exp 1 1 7 0", bus.wb_valid_o, bus.wb_misaligned_o, bus.wb_tag_o, bus.wb_value_o);
        end
        sb.push_back({4'd8, 32'd0, 1'b1}); push_req(0, SZ_H, 0, 8'h05, 32'hFFFF, 4'd8);
        sb.push_back({4'd9, 32'd0, 1'b1}); push_req(1, SZ_H, 1, 8'h03, 32'd0, 4'd9);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic          ls [5]  = '{0, 1, 1, 1, 1};
        logic [1:0]    sz [5]  = '{SZ_W, SZ_W, SZ_H, SZ_B, SZ_B};
        logic          sg [5]  = '{0, 0, 0, 1, 0};
        logic [DA-1:0] ad [5]  = '{8'h30, 8'h30, 8'h32, 8'h30, 8'h33};
        logic [TW-1:0] tg [5]  = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
        sb.push_back({4'd10, 32'hCAFEF00D, 1'b0});
        sb.push_back({4'd11, 32'h0000CAFE, 1'b0});
        sb.push_back({4'd12, 32'h0000000D, 1'b0});
        sb.push_back({4'd13, 32'h000000CA, 1'b0});
        for (int i = 0; i < 4; i++) begin
            drive_req(ls[i], sz[i], sg[i], ad[i], 32'hCAFEF00D, tg[i]); #1;
            checks++;
            if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got=%b exp=1", i, bus.req_ready_o); end
            cyc();
        end
        drive_req(ls[4], sz[4], sg[4], ad[4], 32'd0, tg[4]); #1;
        checks++;
        if (bus.req_ready_o !== 1'b0 || bus.count_o !== 3'd4) begin errors++; $display("FAIL b2b_full got ready=%b count=%0d exp 0 4", bus.req_ready_o, bus.count_o); end
        for (int k = 0; k < 3; k++) begin
            cyc(); #1; checks++;
            if (bus.req_ready_o !== 1'b0 || bus.count_o !== 3'd4) begin errors++; $display("FAIL b2b_hold got ready=%b count=%0d exp 0 4", bus.req_ready_o, bus.count_o); end
        end
        bus.store_commit_i = 1; bus.store_commit_tag_i = 4'd9; #1;
        checks++;
        if (bus.mem_csb_w_o !== 1'b0) begin errors++; $display("FAIL b2b_commit got csb_w=%b exp=0", bus.mem_csb_w_o); end
        cyc();
        bus.store_commit_i = 0; #1;
        checks++;
        if (bus.count_o !== 3'd3 || bus.req_ready_o !== 1'b1 || bus.mem_csb_r_o !== 1'b0) begin
            errors++; $display("FAIL b2b_after_pop got count=%0d ready=%b csb_r=%b exp 3 1 0", bus.count_o, bus.req_ready_o, bus.mem_csb_r_o);
        end
        cyc();
        bus.req_valid_i = 0; #1;
        checks++;
        if (bus.count_o !== 3'd3) begin errors++; $display("FAIL b2b_push_pop got count=%0d exp=3", bus.count_o); end
        wait_drain();
    endtask

    task automatic test_flush();
        preload(6'd14, 32'd0);
        push_req(1, SZ_W, 0, 8'h10, 32'd0, 4'd1);
        bus.flush_i = 1;
        drive_req(1, SZ_W, 0, 8'h10, 32'd0, 4'd2);
        #1; checks++;
        if (bus.mem_csb_r_o !== 1'b0) begin errors++; $display("FAIL fl_issue got csb_r=%b exp=0", bus.mem_csb_r_o); end
        cyc();
        bus.flush_i = 0; bus.req_valid_i = 0; #1;
        checks++;
        if (bus.wb_valid_o !== 1'b0 || bus.count_o !== 3'd0) begin errors++; $display("FAIL fl_suppress got valid=%b count=%0d exp 0 0", bus.wb_valid_o, bus.count_o); end
        cyc(); #1;
        checks++;
        if (bus.count_o !== 3'd0 || bus.mem_csb_r_o !== 1'b1) begin errors++; $display("FAIL fl_dropped got count=%0d csb_r=%b exp 0 1", bus.count_o, bus.mem_csb_r_o); end
        push_req(0, SZ_W, 0, 8'h38, 32'h55AA55AA, 4'd10);
        cyc();
        bus.flush_i = 1; bus.store_commit_i = 1; bus.store_commit_tag_i = 4'd10; #1;
        checks++;
        if (bus.mem_csb_w_o !== 1'b0) begin errors++; $display("FAIL fl_commit got csb_w=%b exp=0", bus.mem_csb_w_o); end
        cyc();
        bus.flush_i = 0; bus.store_commit_i = 0; #1;
        checks++;
        if (bus.count_o !== 3'd0) begin errors++; $display("FAIL fl_commit_count got=%0d exp=0", bus.count_o); end
        sb.push_back({4'd11, 32'h55AA55AA, 1'b0}); push_req(1, SZ_W, 0, 8'h38, 32'd0, 4'd11);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        preload(6'd15, 32'd0);
        push_req(0, SZ_W, 0, 8'h3C, 32'h77777777, 4'd11);
        cyc();
        rst_n = 0; bus.store_commit_i = 1; bus.store_commit_tag_i = 4'd11; #1;
        checks++;
        if (bus.mem_csb_w_o !== 1'b1) begin errors++; $display("FAIL rm_no_write got csb_w=%b exp=1", bus.mem_csb_w_o); end
        cyc();
        bus.store_commit_i = 0; #1;
        checks++;
        if (bus.req_ready_o !== 1'b1 || bus.mem_csb_r_o !== 1'b1 || bus.mem_csb_w_o !== 1'b1 || bus.mem_wmask_o !== 4'b0000 ||
            bus.wb_valid_o !== 1'b0 || bus.wb_misaligned_o !== 1'b0 || bus.wb_tag_o !== 4'd0 || bus.wb_value_o !== 32'd0 || bus.count_o !== 3'd0) begin
            errors++; $display("FAIL rm_outputs got ready=%b csb_r=%b csb_w=%b mask=%b valid=%b mis=%b tag=%0d value=%h count=%0d exp reset values",
                               bus.req_ready_o, bus.mem_csb_r_o, bus.mem_csb_w_o, bus.mem_wmask_o, bus.wb_valid_o,
                               bus.wb_misaligned_o, bus.wb_tag_o, bus.wb_value_o, bus.count_o);
        end
        rst_n = 1;
        cyc(); cyc();
        sb.push_back({4'd12, 32'd0, 1'b0}); push_req(1, SZ_W, 0, 8'h3C, 32'd0, 4'd12);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_lw();
        test_load_format();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
